// File: rtl/sierpinski_stream_checker.sv
// Locks onto the 8-bit LFSR stream on ui_in, then flywheels its prediction and
// counts mismatches. It reports lock status, the FSM state and a saturating error count.
module sierpinski_stream_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        LOST   = 2'b11
    } state_t;

    state_t          state, state_n;
    logic [7:0]      pred, pred_n;
    logic [MW-1:0]   match_cnt, match_n, match_inc;
    logic [LW-1:0]   miss_cnt, miss_n, miss_inc;
    logic [7:0]      err_cnt, err_n;
    logic            pulse, pulse_n;
    logic            accept, sample_valid, err_clear, out_sel;
    logic            unused;

    function automatic logic [7:0] step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    assign sample_valid = uio_in[0];
    assign err_clear    = uio_in[1];
    assign out_sel      = uio_in[2];
    assign unused       = &{1'b0, uio_in[7:3]};
    assign accept       = ena & sample_valid;
    assign match_inc    = match_cnt + MW'(1);
    assign miss_inc     = miss_cnt + LW'(1);

    always_comb begin
        state_n = state;
        pred_n  = pred;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        err_n   = err_cnt;
        pulse_n = 1'b0;
        if (ena) begin
            unique case (state)
                HUNT: begin
                    if (accept && ui_in != 8'h00) begin
                        pred_n  = step(ui_in);
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (accept) begin
                        if (ui_in == pred) begin
                            pred_n  = step(ui_in);
                            match_n = match_inc;
                            if (match_inc == MW'(LOCK_CNT)) begin
                                state_n = LOCKED;
                                miss_n  = '0;
                            end
                        end else begin
                            // a wrong byte is the best guess for a new seed unless it is the illegal zero
                            pred_n  = step(ui_in);
                            match_n = '0;
                            if (ui_in == 8'h00) state_n = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        pred_n = step(pred);
                        if (ui_in == pred) begin
                            miss_n = '0;
                        end else begin
                            miss_n  = miss_inc;
                            pulse_n = 1'b1;
                            if (err_cnt != 8'hFF) err_n = err_cnt + 8'd1;
                            if (miss_inc == LW'(LOSS_CNT)) state_n = LOST;
                        end
                    end
                end
                LOST: begin
                    state_n = HUNT;
                    match_n = '0;
                    miss_n  = '0;
                end
                default: state_n = HUNT;
            endcase
            if (err_clear) err_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
            pulse     <= 1'b0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            err_cnt   <= err_n;
            pulse     <= pulse_n;
        end
    end

    assign uo_out  = out_sel ? pred : err_cnt;
    assign uio_out = {state, pulse, state == LOCKED, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_sierpinski_stream_checker.sv
// Scoreboard bench for sierpinski_stream_checker: a reference model predicts the
// outputs for every driven cycle and a monitor compares them after each rising edge.
module tb_sierpinski_stream_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    sierpinski_stream_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    typedef struct {
        string      tag;
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // reference model state (0 hunt, 1 verify, 2 locked, 3 lost)
    int         m_state = 0;
    int         m_match = 0;
    int         m_miss = 0;
    logic [7:0] m_pred = 8'h00;
    logic [7:0] m_err = 8'h00;
    logic       m_pulse = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr(input logic [7:0] q);
        logic fb;
        fb = q[7] ^ q[5] ^ q[4] ^ q[3];
        return (q << 1) | {7'd0, fb};
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic v, input logic c,
                              input logic [7:0] d);
        logic np;
        np = 1'b0;
        if (r) begin
            m_state = 0; m_match = 0; m_miss = 0; m_pred = 8'h00; m_err = 8'h00;
        end else if (e) begin
            case (m_state)
                0: if (v && d != 8'h00) begin
                    m_pred = lfsr(d); m_match = 0; m_state = 1;
                end
                1: if (v) begin
                    if (d == m_pred) begin
                        m_match++;
                        m_pred = lfsr(d);
                        if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
                    end else if (d != 8'h00) begin
                        m_pred = lfsr(d); m_match = 0;
                    end else begin
                        m_pred = lfsr(d); m_match = 0; m_state = 0;
                    end
                end
                2: if (v) begin
                    if (d != m_pred) begin
                        m_miss++;
                        np = 1'b1;
                        if (m_err != 8'hFF) m_err = m_err + 8'd1;
                        if (m_miss == LOSS) m_state = 3;
                    end else begin
                        m_miss = 0;
                    end
                    m_pred = lfsr(m_pred);
                end
                default: begin m_state = 0; m_match = 0; m_miss = 0; end
            endcase
            if (c) m_err = 8'h00;
        end
        m_pulse = np;
    endtask

    task automatic cyc(input string tag, input logic r, input logic e, input logic v,
                       input logic c, input logic s, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        rst    = r;
        ena    = e;
        ui_in  = d;
        uio_in = {5'($urandom), s, c, v};
        model_edge(r, e, v, c, d);
        x.tag = tag;
        x.uo  = s ? m_pred : m_err;
        x.uio = {2'(m_state), m_pulse, (m_state == 2), 4'b0000};
        sb.push_back(x);
    endtask

    // let the pending edge happen, then look at the DUT directly
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic lock_from(input string tag, input logic [7:0] seed, input logic s);
        cyc(tag, 0, 1, 1, 0, s, seed);
        repeat (LOCK) cyc(tag, 0, 1, 1, 0, s, m_pred);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "/uo_out"}, 16'(uo_out), 16'(e.uo));
            check({e.tag, "/uio_out"}, 16'(uio_out), 16'(e.uio));
            check({e.tag, "/uio_oe"}, 16'(uio_oe), 16'h00F0);
        end
    end

    initial begin
        cyc("reset", 1, 1, 1, 1, 0, 8'h5A);
        cyc("reset2", 1, 0, 0, 0, 1, 8'h00);

        // acquisition from the canonical seed
        cyc("s01", 0, 1, 1, 0, 0, 8'h01);
        settle();
        check("verify_after_01", 16'(uio_out[7:6]), 16'h0001);
        cyc("s02", 0, 1, 1, 0, 0, 8'h02);
        cyc("s04", 0, 1, 1, 0, 0, 8'h04);
        cyc("s08", 0, 1, 1, 0, 0, 8'h08);
        settle();
        check("not_locked_yet", 16'(uio_out[4]), 16'h0000);
        cyc("s11", 0, 1, 1, 0, 1, 8'h11);
        settle();
        check("locked_after_5", 16'(uio_out[4]), 16'h0001);
        check("pred_after_11", 16'(uo_out), 16'h0023);

        // single corrupted byte while locked
        cyc("corrupt", 0, 1, 1, 0, 1, 8'h22);
        settle();
        check("pulse_high", 16'(uio_out[5]), 16'h0001);
        check("flywheel_pred", 16'(uo_out), 16'h0047);
        cyc("recover", 0, 1, 1, 0, 0, 8'h47);
        settle();
        check("pulse_one_cycle", 16'(uio_out[5]), 16'h0000);
        check("err_one", 16'(uo_out), 16'h0001);
        check("still_locked", 16'(uio_out[4]), 16'h0001);
        repeat (3) cyc("track", 0, 1, 1, 0, 1, m_pred);

        // loss of lock, then a sample offered during LOST is dropped
        repeat (3) cyc("wrong", 0, 1, 1, 0, 0, m_pred ^ 8'h80);
        settle();
        check("lost_state", 16'(uio_out[7:6]), 16'h0003);
        check("err_four", 16'(uo_out), 16'h0004);
        cyc("lost_drop", 0, 1, 1, 0, 1, 8'h33);
        settle();
        check("hunt_after_lost", 16'(uio_out[7:6]), 16'h0000);
        cyc("reseed", 0, 1, 1, 0, 1, 8'h33);
        settle();
        check("reseed_pred", 16'(uo_out), 16'h0066);

        // verify-phase mismatch re-seeds, zero returns to hunt
        cyc("v_ok", 0, 1, 1, 0, 1, 8'h66);
        cyc("v_bad", 0, 1, 1, 0, 1, 8'h09);
        cyc("v_ok2", 0, 1, 1, 0, 1, 8'h13);
        cyc("v_zero", 0, 1, 1, 0, 1, 8'h00);

        // zeros in hunt, then disabled input
        cyc("rst_b", 1, 1, 1, 0, 0, 8'h00);
        repeat (4) cyc("zeros", 0, 1, 1, 0, 0, 8'h00);
        cyc("ena0_a", 0, 0, 1, 0, 1, 8'h01);
        cyc("ena0_b", 0, 0, 1, 1, 1, 8'h02);
        cyc("ena0_c", 0, 0, 1, 0, 0, 8'h04);
        settle();
        check("ena0_hunt", 16'(uio_out), 16'h0000);
        check("ena0_uo", 16'(uo_out), 16'h0000);

        // saturation through repeated lock/loss cycles
        for (int i = 0; i < 90; i++) begin
            lock_from("sat_lock", 8'($urandom_range(1, 255)), i[0]);
            repeat (LOSS) cyc("sat_miss", 0, 1, 1, 0, 0, m_pred ^ 8'h01);
            cyc("sat_lost", 0, 1, 1, 0, 0, 8'($urandom));
        end
        settle();
        check("err_saturated", 16'(uo_out), 16'h00FF);

        // clear on the same edge as a mismatch
        lock_from("clr_lock", 8'hA5, 0);
        cyc("clr_miss", 0, 1, 1, 1, 0, m_pred ^ 8'h10);
        settle();
        check("clear_wins", 16'(uo_out), 16'h0000);
        check("clear_keeps_lock", 16'(uio_out[4]), 16'h0001);

        // build error count 5 while staying locked, then reset
        cyc("ok", 0, 1, 1, 0, 0, m_pred);
        for (int i = 0; i < 5; i++) begin
            cyc("e5_miss", 0, 1, 1, 0, 0, m_pred ^ 8'h04);
            cyc("e5_ok", 0, 1, 1, 0, 0, m_pred);
        end
        settle();
        check("err_five", 16'(uo_out), 16'h0005);
        check("locked_before_rst", 16'(uio_out[4]), 16'h0001);
        cyc("rst_locked", 1, 1, 1, 1, 1, m_pred ^ 8'h04);
        settle();
        check("rst_uo", 16'(uo_out), 16'h0000);
        check("rst_uio", 16'(uio_out), 16'h0000);

        cyc("idle", 0, 1, 0, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 16'(sb.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
